// File: rtl/l1_mem_arbiter.sv
// L1 memory arbiter: merges I$ (ctrl) and D$ (data) request streams onto a
// single memory request port and routes responses back by path tag.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | output slot empty; arbitrate eligible requesters this cycle
// REQ   | output slot holds one request; wait for i_req_mem_ready
//
// Each path may have at most one transaction in flight (out_ctrl/out_data).
// Data normally wins a contest; ctrl wins once it has lost starve_limit
// contests in a row.
module l1_mem_arbiter #(
    parameter int starve_limit = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_ctrl_valid,
    input  logic [2:0]  i_req_ctrl_type,
    input  logic [2:0]  i_req_ctrl_size,
    input  logic [47:0] i_req_ctrl_addr,
    output logic        o_req_ctrl_ready,
    input  logic        i_req_data_valid,
    input  logic [2:0]  i_req_data_type,
    input  logic [2:0]  i_req_data_size,
    input  logic [47:0] i_req_data_addr,
    output logic        o_req_data_ready,
    output logic        o_req_mem_valid,
    output logic        o_req_mem_path,
    output logic [2:0]  o_req_mem_type,
    output logic [2:0]  o_req_mem_size,
    output logic [47:0] o_req_mem_addr,
    input  logic        i_req_mem_ready,
    input  logic        i_resp_mem_valid,
    input  logic        i_resp_mem_path,
    output logic        o_resp_ctrl_valid,
    output logic        o_resp_data_valid,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(starve_limit);

    state_t     state;
    logic       out_ctrl;
    logic       out_data;
    logic [3:0] starve_cnt;

    logic elig_ctrl;
    logic elig_data;
    logic gnt_ctrl;
    logic gnt_data;
    logic handshake;
    logic resp_ctrl;
    logic resp_data;

    // Eligibility and grant decision; flags are the registered values, so a
    // flag being cleared by a response this cycle still blocks its path.
    always_comb begin
        elig_ctrl = (state == IDLE) & i_req_ctrl_valid & ~out_ctrl;
        elig_data = (state == IDLE) & i_req_data_valid & ~out_data;
        gnt_ctrl  = elig_ctrl & (~elig_data | (starve_cnt >= LIMIT));
        gnt_data  = elig_data & ~gnt_ctrl;
        handshake = (state == REQ) & i_req_mem_ready;
        resp_ctrl = i_resp_mem_valid & ~i_resp_mem_path;
        resp_data = i_resp_mem_valid & i_resp_mem_path;
    end

    assign o_req_ctrl_ready  = gnt_ctrl;
    assign o_req_data_ready  = gnt_data;
    assign o_resp_ctrl_valid = resp_ctrl;
    assign o_resp_data_valid = resp_data;
    assign o_busy            = (state == REQ) | out_ctrl | out_data;

    // Request slot FSM, outstanding flags, starvation counter and error flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            o_req_mem_valid <= 1'b0;
            o_req_mem_path  <= 1'b0;
            o_req_mem_type  <= 3'd0;
            o_req_mem_size  <= 3'd0;
            o_req_mem_addr  <= 48'd0;
            out_ctrl        <= 1'b0;
            out_data        <= 1'b0;
            starve_cnt      <= 4'd0;
            o_err           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_ctrl) begin
                        state           <= REQ;
                        o_req_mem_valid <= 1'b1;
                        o_req_mem_path  <= 1'b0;
                        o_req_mem_type  <= i_req_ctrl_type;
                        o_req_mem_size  <= i_req_ctrl_size;
                        o_req_mem_addr  <= i_req_ctrl_addr;
                    end else if (gnt_data) begin
                        state           <= REQ;
                        o_req_mem_valid <= 1'b1;
                        o_req_mem_path  <= 1'b1;
                        o_req_mem_type  <= i_req_data_type;
                        o_req_mem_size  <= i_req_data_size;
                        o_req_mem_addr  <= i_req_data_addr;
                    end
                end
                REQ: begin
                    if (i_req_mem_ready) begin
                        state           <= IDLE;
                        o_req_mem_valid <= 1'b0;
                    end
                end
                default: begin
                    state           <= IDLE;
                    o_req_mem_valid <= 1'b0;
                end
            endcase

            // A handshake setting a flag takes precedence over a response
            // clearing it in the same cycle.
            if (handshake & ~o_req_mem_path) begin
                out_ctrl <= 1'b1;
            end else if (resp_ctrl) begin
                out_ctrl <= 1'b0;
            end

            if (handshake & o_req_mem_path) begin
                out_data <= 1'b1;
            end else if (resp_data) begin
                out_data <= 1'b0;
            end

            if (gnt_ctrl) begin
                starve_cnt <= 4'd0;
            end else if (gnt_data & elig_ctrl & (starve_cnt != 4'hF)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            if ((resp_ctrl & ~out_ctrl) | (resp_data & ~out_data)) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_l1_mem_arbiter;

    localparam int LIMIT = 4;

    logic        i_clk;
    logic        i_rst;
    logic        vc, vd;
    logic [2:0]  tc, sc, td, sd;
    logic [47:0] ac, ad;
    logic        ready_c, ready_d;
    logic        mem_valid, mem_path;
    logic [2:0]  mem_type, mem_size;
    logic [47:0] mem_addr;
    logic        mem_ready;
    logic        rv, rp;
    logic        resp_c, resp_d, busy, err;

    l1_mem_arbiter #(.starve_limit(LIMIT)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_req_ctrl_valid (vc),
        .i_req_ctrl_type  (tc),
        .i_req_ctrl_size  (sc),
        .i_req_ctrl_addr  (ac),
        .o_req_ctrl_ready (ready_c),
        .i_req_data_valid (vd),
        .i_req_data_type  (td),
        .i_req_data_size  (sd),
        .i_req_data_addr  (ad),
        .o_req_data_ready (ready_d),
        .o_req_mem_valid  (mem_valid),
        .o_req_mem_path   (mem_path),
        .o_req_mem_type   (mem_type),
        .o_req_mem_size   (mem_size),
        .o_req_mem_addr   (mem_addr),
        .i_req_mem_ready  (mem_ready),
        .i_resp_mem_valid (rv),
        .i_resp_mem_path  (rp),
        .o_resp_ctrl_valid(resp_c),
        .o_resp_data_valid(resp_d),
        .o_busy           (busy),
        .o_err            (err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a one-entry slot of pending requests, a per-path
    // in-flight bit, a loss counter and a sticky error bit.
    typedef struct {
        bit          path;
        logic [2:0]  typ;
        logic [2:0]  size;
        logic [47:0] addr;
    } req_t;

    req_t        slot_q[$];
    req_t        last_req;
    bit          inflight[2];
    int          losses;
    bit          m_err;
    int          winner;     // -1 none, 0 ctrl, 1 data
    bit          ctrl_elig;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        slot_q.delete();
        last_req = '{path: 1'b0, typ: 3'd0, size: 3'd0, addr: 48'd0};
        inflight[0] = 1'b0;
        inflight[1] = 1'b0;
        losses = 0;
        m_err = 1'b0;
        winner = -1;
        ctrl_elig = 1'b0;
    endtask

    // Settle combinational outputs, decide the expected winner and compare
    // every DUT output against the model.
    task automatic settle_check();
        bit de;
        #1;
        winner    = -1;
        ctrl_elig = (slot_q.size() == 0) && vc && !inflight[0];
        de        = (slot_q.size() == 0) && vd && !inflight[1];
        if (ctrl_elig && de) winner = (losses >= LIMIT) ? 0 : 1;
        else if (ctrl_elig) winner = 0;
        else if (de) winner = 1;
        chk("ready_ctrl", ready_c, 64'(winner == 0));
        chk("ready_data", ready_d, 64'(winner == 1));
        chk("mem_valid", mem_valid, 64'(slot_q.size() != 0));
        chk("mem_path", mem_path, 64'(last_req.path));
        chk("mem_type", mem_type, 64'(last_req.typ));
        chk("mem_size", mem_size, 64'(last_req.size));
        chk("mem_addr", mem_addr, 64'(last_req.addr));
        chk("resp_ctrl", resp_c, 64'(rv && !rp));
        chk("resp_data", resp_d, 64'(rv && rp));
        chk("busy", busy, 64'((slot_q.size() != 0) || inflight[0] || inflight[1]));
        chk("err", err, 64'(m_err));
    endtask

    // Advance one clock and apply the model's transaction rules.
    task automatic tick();
        bit set_f[2];
        @(posedge i_clk);
        if (i_rst) begin
            m_reset();
        end else begin
            set_f[0] = 1'b0;
            set_f[1] = 1'b0;
            if (slot_q.size() != 0 && mem_ready) begin
                set_f[slot_q[0].path] = 1'b1;
                void'(slot_q.pop_front());
            end
            if (rv) begin
                if (!inflight[rp]) m_err = 1'b1;
                inflight[rp] = 1'b0;
            end
            for (int p = 0; p < 2; p++) if (set_f[p]) inflight[p] = 1'b1;
            if (winner == 0) begin
                last_req = '{path: 1'b0, typ: tc, size: sc, addr: ac};
                slot_q.push_back(last_req);
                losses = 0;
            end else if (winner == 1) begin
                last_req = '{path: 1'b1, typ: td, size: sd, addr: ad};
                slot_q.push_back(last_req);
                if (ctrl_elig && losses < 15) losses++;
            end
        end
        @(negedge i_clk);
    endtask

    task automatic quiet();
        vc = 0; vd = 0; mem_ready = 0; rv = 0; rp = 0;
    endtask

    task automatic apply_reset();
        quiet();
        i_rst = 1'b1;
        m_reset();
        @(negedge i_clk);
        settle_check();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic step();
        settle_check();
        tick();
    endtask

    int          grants[$];
    int          budget;
    logic [63:0] rnd;
    int          r;

    initial begin
        quiet();
        tc = 3'd1; sc = 3'd2; ac = 48'h0;
        td = 3'd5; sd = 3'd3; ad = 48'h0;
        i_rst = 1'b0;
        m_reset();
        #1 i_rst = 1'b1;
        @(negedge i_clk);
        // Reset state
        settle_check();
        chk("rst_valid", mem_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", mem_addr, 0);
        tick();
        i_rst = 1'b0;

        // Single ctrl request
        vc = 1; ac = 48'h000000001000; tc = 3'd2; sc = 3'd3; mem_ready = 1;
        settle_check();
        chk("single_grant", ready_c, 1);
        tick();
        vc = 0;
        settle_check();
        chk("single_valid", mem_valid, 1);
        chk("single_path", mem_path, 0);
        chk("single_addr", mem_addr, 64'h1000);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle_check();
            chk("single_busy", busy, 1);
            tick();
        end
        rv = 1; rp = 0;
        settle_check();
        chk("single_resp", resp_c, 1);
        tick();
        rv = 0;
        settle_check();
        chk("single_idle", busy, 0);
        tick();

        // Starvation: both valid whenever both could contend
        apply_reset();
        mem_ready = 1;
        budget = 0;
        grants.delete();
        while (grants.size() < 6 && budget < 80) begin
            vd = 1;
            vc = (slot_q.size() == 0) && !inflight[0] && !inflight[1];
            rv = inflight[0] || inflight[1];
            rp = inflight[1];
            ad = 48'h2000 + 48'(budget);
            settle_check();
            if (ready_c) grants.push_back(0);
            if (ready_d) grants.push_back(1);
            tick();
            budget++;
        end
        if (grants.size() < 6) chk("starve_timeout", 0, 1);
        else begin
            for (int i = 0; i < 4; i++) chk("starve_data_first", 64'(grants[i]), 1);
            chk("starve_ctrl_fifth", 64'(grants[4]), 0);
            chk("starve_cleared", 64'(grants[5]), 1);
        end

        // Backpressure for 5 cycles
        apply_reset();
        vc = 1; vd = 1; ad = 48'hABCDEF012345; td = 3'd6; sd = 3'd1;
        settle_check();
        tick();
        for (int i = 0; i < 5; i++) begin
            ad = 48'(i * 48'h111); ac = 48'(i * 48'h777);
            settle_check();
            chk("stall_addr", mem_addr, 64'hABCDEF012345);
            chk("stall_type", mem_type, 6);
            chk("stall_nordy", 64'({ready_c, ready_d}), 0);
            tick();
        end
        mem_ready = 1;
        settle_check();
        chk("stall_valid_hs", mem_valid, 1);
        tick();
        vc = 0; vd = 0;
        settle_check();
        chk("stall_done", mem_valid, 0);
        tick();

        // Unexpected data response
        apply_reset();
        rv = 1; rp = 1;
        settle_check();
        chk("bogus_fwd", resp_d, 1);
        tick();
        rv = 0;
        for (int i = 0; i < 3; i++) begin
            settle_check();
            chk("bogus_sticky", err, 1);
            tick();
        end
        apply_reset();
        settle_check();
        chk("bogus_cleared", err, 0);
        tick();

        // One data transaction in flight blocks the next; ctrl still served
        vd = 1; mem_ready = 1; ad = 48'h3000;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            settle_check();
            chk("blk_data", ready_d, 0);
            tick();
        end
        vc = 1;
        settle_check();
        chk("blk_ctrl_ok", ready_c, 1);
        tick();
        vc = 0;
        step();
        rv = 1; rp = 1;
        settle_check();
        chk("blk_same_cycle", ready_d, 0);
        tick();
        rv = 0;
        settle_check();
        chk("blk_released", ready_d, 1);
        tick();
        vd = 0;
        step();

        // Async reset while the slot is full
        apply_reset();
        vc = 1; ac = 48'h4000;
        step();
        vc = 0;
        settle_check();
        chk("arst_pre", mem_valid, 1);
        #2;
        i_rst = 1'b1;
        m_reset();
        #1;
        chk("arst_valid", mem_valid, 0);
        chk("arst_busy", busy, 0);
        @(negedge i_clk);
        tick();
        i_rst = 1'b0;
        vc = 1; ac = 48'h5000; mem_ready = 1;
        settle_check();
        chk("arst_regrant", ready_c, 1);
        tick();
        vc = 0;
        settle_check();
        chk("arst_addr", mem_addr, 64'h5000);
        tick();
        rv = 1; rp = 1;
        step();
        rv = 0;

        // Random traffic
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            vc = ($urandom_range(0, 3) != 0);
            vd = ($urandom_range(0, 3) != 0);
            rnd = {$urandom, $urandom}; ac = rnd[47:0];
            rnd = {$urandom, $urandom}; ad = rnd[47:0];
            tc = 3'($urandom); sc = 3'($urandom);
            td = 3'($urandom); sd = 3'($urandom);
            mem_ready = ($urandom_range(0, 2) != 0);
            r = int'($urandom_range(0, 15));
            rv = 0; rp = 0;
            if (r == 0) begin
                rv = 1; rp = 1'($urandom);
            end else if (r < 8 && (inflight[0] || inflight[1])) begin
                rv = 1;
                if (inflight[0] && inflight[1]) rp = 1'($urandom);
                else rp = inflight[1];
            end
            if (cyc == 300) begin
                apply_reset();
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
